// File: rtl/scratch_pad_read_buffer.sv
// Read-return buffer for one scratch pad port.
// Every (in_valid, in_q) beat from the scratch pad is stored in a small
// circular FIFO and handed to the consumer over a valid/ready handshake.
// The stall output is raised early enough that beats still in flight in
// the scratch pad pipeline always find room in the buffer.

module scratch_pad_read_buffer #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8,
   parameter int SLACK = 4,
   localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_q,
   output logic                 stall,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   input  logic                 out_ready,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 overflow
);

   localparam int PTR_WIDTH = $clog2(DEPTH);

   // Stall must fire while at least SLACK entries are still free, so the
   // threshold is the occupancy at which exactly SLACK slots remain.
   localparam logic [CNT_WIDTH-1:0] FULL_COUNT   = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] STALL_THRESH = CNT_WIDTH'(DEPTH - SLACK);

   // Reject parameter sets that cannot protect in-flight beats or that
   // break the natural pointer wrap.
   if (DEPTH < SLACK + 1) begin : gen_bad_depth
      $error("scratch_pad_read_buffer: DEPTH must be at least SLACK+1");
   end
   if ((DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_pow2
      $error("scratch_pad_read_buffer: DEPTH must be a power of two");
   end

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [PTR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 stall_q, stall_d;
   logic                 overflow_q, overflow_d;

   logic isEmpty;
   logic isFull;
   logic push;
   logic pop;
   logic dropBeat;

   // Handshake qualifiers: a pop frees a slot in the same cycle, so a beat
   // arriving at full is still accepted when the consumer takes the head.
   always_comb begin
      isEmpty  = (count_q == '0);
      isFull   = (count_q == FULL_COUNT);
      pop      = !isEmpty && out_ready;
      push     = in_valid && (!isFull || pop);
      dropBeat = in_valid && isFull && !pop;
   end

   // Next-state for pointers, occupancy, stall and the sticky overflow flag.
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (push) begin
         wrPtr_d = wrPtr_q + PTR_WIDTH'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PTR_WIDTH'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_WIDTH'(1);
         2'b01:   count_d = count_q - CNT_WIDTH'(1);
         default: count_d = count_q;
      endcase

      if (dropBeat) begin
         overflow_d = 1'b1;
      end

      stall_d = (count_d >= STALL_THRESH);
   end

   // Control state; reset discards everything held in the buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         stall_q    <= stall_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage array; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= in_q;
      end
   end

   // Outputs come straight from registers, keeping in_q off any
   // combinational path to the consumer.
   always_comb begin
      out_valid = !isEmpty;
      out_data  = mem_q[rdPtr_q];
      count     = count_q;
      stall     = stall_q;
      overflow  = overflow_q;
   end

endmodule

// File: tb/tb_scratch_pad_read_buffer.sv
// Directed testbench for scratch_pad_read_buffer (WIDTH=64, DEPTH=8, SLACK=4).

module tb_scratch_pad_read_buffer;

   localparam int WIDTH     = 64;
   localparam int DEPTH     = 8;
   localparam int SLACK     = 4;
   localparam int CNT_WIDTH = 4;

   logic                 clk;
   logic                 rst;
   logic                 inValid;
   logic [WIDTH-1:0]     inQ;
   logic                 stall;
   logic                 outValid;
   logic [WIDTH-1:0]     outData;
   logic                 outReady;
   logic [CNT_WIDTH-1:0] count;
   logic                 overflow;

   int errors;
   int checks;

   scratch_pad_read_buffer #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .SLACK(SLACK)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (inValid),
      .in_q     (inQ),
      .stall    (stall),
      .out_valid(outValid),
      .out_data (outData),
      .out_ready(outReady),
      .count    (count),
      .overflow (overflow)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, cross the next rising edge, settle 1 ns.
   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] q, input logic r);
      inValid  = v;
      inQ      = q;
      outReady = r;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Fill the empty buffer with DEPTH consecutive values starting at base.
   task automatic fillBuffer(input int base);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, WIDTH'(base + i), 1'b0);
      end
   endtask

   initial begin
      int sent;
      int got;

      errors   = 0;
      checks   = 0;
      rst      = 1'b0;
      inValid  = 1'b0;
      inQ      = '0;
      outReady = 1'b0;

      // 1. Reset and idle
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_count", count, 0);
      checkOutput("rst_valid", outValid, 0);
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_ovf", overflow, 0);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, '0, 1'b0);
         checkOutput("idle_count", count, 0);
         checkOutput("idle_valid", outValid, 0);
         checkOutput("idle_stall", stall, 0);
      end
      checkOutput("idle_ovf", overflow, 0);

      // 2. Single read passthrough
      applyStimulus(1'b1, 64'd42, 1'b1);
      checkOutput("pass_valid", outValid, 1);
      checkOutput("pass_data", outData, 42);
      checkOutput("pass_count1", count, 1);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("pass_valid_off", outValid, 0);
      checkOutput("pass_count0", count, 0);

      // 3. Stall threshold
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, WIDTH'(i), 1'b0);
         checkOutput("thr_count", count, CNT_WIDTH'(i));
         checkOutput("thr_stall", stall, (i >= 4) ? 1 : 0);
      end
      for (int i = 5; i <= 8; i++) begin
         applyStimulus(1'b1, WIDTH'(i), 1'b0);
      end
      checkOutput("thr_full_count", count, 8);
      checkOutput("thr_full_ovf", overflow, 0);
      checkOutput("thr_full_stall", stall, 1);
      for (int k = 1; k <= 8; k++) begin
         checkOutput("thr_pop_data", outData, WIDTH'(k));
         applyStimulus(1'b0, '0, 1'b1);
         checkOutput("thr_pop_count", count, CNT_WIDTH'(8 - k));
         checkOutput("thr_pop_stall", stall, ((8 - k) >= 4) ? 1 : 0);
      end

      // 4. Full with simultaneous push and pop
      fillBuffer(11);
      checkOutput("fpp_count_pre", count, 8);
      applyStimulus(1'b1, 64'd99, 1'b1);
      checkOutput("fpp_count", count, 8);
      checkOutput("fpp_ovf", overflow, 0);
      for (int k = 0; k < 8; k++) begin
         checkOutput("fpp_data", outData, (k < 7) ? WIDTH'(12 + k) : 64'd99);
         applyStimulus(1'b0, '0, 1'b1);
      end
      checkOutput("fpp_empty", outValid, 0);

      // 5. Overflow
      fillBuffer(21);
      applyStimulus(1'b1, 64'd77, 1'b0);
      checkOutput("ovf_flag", overflow, 1);
      checkOutput("ovf_count", count, 8);
      checkOutput("ovf_head", outData, 21);
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("ovf_hold_data", outData, 21);
      checkOutput("ovf_hold_count", count, 8);
      for (int k = 0; k < 8; k++) begin
         checkOutput("ovf_drain", outData, WIDTH'(21 + k));
         applyStimulus(1'b0, '0, 1'b1);
      end
      checkOutput("ovf_drain_count", count, 0);
      checkOutput("ovf_sticky", overflow, 1);

      // 6. Wrap-around stream; the upstream model honours stall
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
         logic v;
         logic r;
         v = (sent < 20) && !stall;
         r = (cyc % 2) == 0;
         if (outValid && r) begin
            checkOutput("wrap_data", outData, WIDTH'(got));
            got++;
         end
         applyStimulus(v, WIDTH'(sent), r);
         if (v) sent++;
      end
      checkOutput("wrap_all_received", WIDTH'(got), 20);
      checkOutput("wrap_count", count, 0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, WIDTH'(30 + i), 1'b0);
      end
      inValid = 1'b0;
      checkOutput("mid_count_pre", count, 5);
      checkOutput("mid_stall_pre", stall, 1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("mid_count", count, 0);
      checkOutput("mid_valid", outValid, 0);
      checkOutput("mid_stall", stall, 0);
      checkOutput("mid_ovf", overflow, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(1'b1, 64'd55, 1'b0);
      checkOutput("post_count", count, 1);
      checkOutput("post_data", outData, 55);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scratch_pad_read_buffer.md
Name: scratch_pad_read_buffer

Overview:
Per-port read-return buffer that sits directly downstream of a scratch_pad_gold read port. It captures every (valid, q) beat the scratch pad produces into a small FIFO and presents it to the consumer over a valid/ready handshake. It drives the scratch pad's per-port stall early enough that in-flight reads never overflow the buffer. One instance per scratch pad port.

Parameters:
WIDTH, 64, data width; matches the scratch pad WIDTH.
DEPTH, 8, FIFO entries; power of 2, must be >= SLACK+1.
SLACK, 4, max beats the scratch pad may still deliver after stall is seen asserted; covers read latency plus the stall register.
CNT_WIDTH, log2(DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset; asynchronous, active-low.
in_valid  input  1  scratch pad valid for this port; one beat per cycle when high.
in_q  input  WIDTH  scratch pad q slice for this port.
stall  output  1  to scratch pad stall for this port; registered.
out_valid  output  1  head entry available to the consumer.
out_data  output  WIDTH  head entry data.
out_ready  input  1  consumer accepts the head entry when out_valid is also high.
count  output  CNT_WIDTH  current occupancy, 0..DEPTH.
overflow  output  1  sticky error flag: a beat arrived while full with no pop.

Behaviour:
- Reset (rst=0, asynchronous): count=0, read and write pointers=0, stall=0, out_valid=0, overflow=0. out_data is don't-care while out_valid=0. Any data in the buffer is discarded when reset is asserted mid-operation.
- Storage: circular buffer of DEPTH x WIDTH registers. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- push = in_valid && (count < DEPTH || pop).
- pop = out_valid && out_ready.
- out_valid = (count != 0). out_data = mem[rd_ptr], with no combinational path from in_q.
- Latency: a beat pushed at edge N is visible on out_valid/out_data after edge N. It can be popped at edge N+1 at the earliest.
- Count update: count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - At full, a simultaneous push and pop is legal and stores the new beat.
  - At empty, a simultaneous push and pop is impossible because out_valid=0.
- Stall: registered. stall <= (count_next >= DEPTH - SLACK). It deasserts the cycle after count_next drops below the threshold.
- Overflow: if in_valid && count==DEPTH && !pop, the beat is dropped, pointers and count are unchanged, and overflow is set. overflow clears only on reset.
- Backpressure on the consumer side: while out_ready=0, out_data and out_valid are held stable.
- Ordering: strictly FIFO; beats are never reordered or duplicated.

Test Plan:
1. Reset and idle: assert rst=0 for 3 cycles, then release. Required: count=0, out_valid=0, stall=0, overflow=0; nothing changes with no stimulus for 20 cycles.
2. Single read passthrough: in_valid=1 for one cycle with in_q=42, out_ready=1. Required: out_valid=1 with out_data=42 for exactly one cycle after the push edge, then count returns to 0.
3. Stall threshold (DEPTH=8, SLACK=4): out_ready=0, push 4 beats 1..4. Required: stall rises the cycle after the 4th push (count=4). Push 4 more (5..8): count=8, overflow=0. Then out_ready=1: pops return 1..8 in order, and stall drops after count falls to 3.
4. Full with simultaneous push/pop: fill to 8, then in_valid=1 with in_q=99 and out_ready=1 on the same cycle. Required: count stays 8, overflow=0, and 99 is emitted after the prior 7 entries.
5. Overflow: fill to 8, out_ready=0, in_valid=1 with in_q=77. Required: overflow=1 and sticky, count=8, and 77 never appears on out_data.
6. Wrap-around and mid-operation reset: stream 20 beats (values 0..19) with out_ready toggling 1,0,1,0. Required: output is 0..19 in order. Then assert rst=0 while count=5: count=0 and out_valid=0 immediately, without waiting for a clock edge.
